// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: default width and down-counter state encoding.
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } dc_state_t;

endpackage

// File: rtl/down_counter_16_if.sv
// Control/status bundle for down_counter_16; master drives load/start/pause, slave is the counter.
interface down_counter_16_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;
  // Borrow out of the MSB while decrementing in RUN; never expected to rise.
  logic             underflow;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, done, zero, underflow
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, done, zero, underflow
  );

endinterface

// File: rtl/half_subtractor.sv
// One-bit half subtractor (a - b), the cell of the decrement borrow chain.
module half_subtractor (
  input  logic a_i,
  input  logic b_i,
  output logic diff_o,
  output logic borrow_o
);

  assign diff_o   = a_i ^ b_i;
  assign borrow_o = ~a_i & b_i;

endmodule

// File: rtl/down_counter_16.sv
// Loadable down counter with start/pause control and a one-cycle done pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the reload value after each done.
module down_counter_16
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  down_counter_16_if.slave  bus_io
);

  dc_state_t        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH:0]   borrow;

  // Bit 0 subtracts one; each higher bit subtracts the borrow from below.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    half_subtractor u_hs (
      .a_i      (count_q[i]),
      .b_i      (borrow[i]),
      .diff_o   (count_dec[i]),
      .borrow_o (borrow[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus_io.load) begin
      // Load wins everywhere: capture, abort any count, return to idle.
      state_q  <= StIdle;
      count_q  <= bus_io.load_val;
      reload_q <= bus_io.load_val;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            if (count_q != '0) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (!bus_io.pause) begin
            count_q <= count_dec;
            if (count_q == WIDTH'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          done_q <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            state_q <= StRun;
            count_q <= reload_q;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
  // Reload is held for restart via a fresh load/start but has no reader in one-shot builds.
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  assign bus_io.count     = count_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.zero      = (count_q == '0);
  assign bus_io.underflow = (state_q == StRun) && !bus_io.pause && borrow[WIDTH];

endmodule
